hitmap_serializer: RTL and testbench
====================================

# hitmap_serializer

Downstream of each crate mapping stage. Captures the one-cycle 38x38 hit-map frame (header word plus 38 row words) and streams it out one 38-bit word per cycle on a valid/ready interface, tagged with row index and start/end markers. Optionally suppresses all-zero rows. Reports per-frame hit count and counts frames dropped while busy.

## Interface
Parameters:
- SKIP_EMPTY, 1, when 1 all-zero rows are not transmitted; when 0 all 38 rows are sent.
- DROP_W, 16, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- array_header  input  38  frame header from mapping stage. Bit 37 = frame-present strobe; nonzero only in the frame cycle.
- array_in00 … array_in37  input  38 each  hit rows y=0..37; bit x = hit at (x,y). Valid only in the cycle array_header[37]=1.
- dout  output  38  output word: header or row.
- dout_row  output  6  63 for header word; 0..37 for row words.
- dout_sof  output  1  1 on header word.
- dout_eof  output  1  1 on last word of frame.
- dout_valid  output  1  output word valid.
- dout_ready  input  1  consumer accepts word when dout_valid && dout_ready.
- busy  output  1  frame held (state != IDLE).
- hit_count  output  11  popcount of all 1444 row bits of last captured frame.
- overflow  output  1  one-cycle pulse when an arriving frame is dropped.
- drop_count  output  DROP_W  frames dropped since reset; saturates at all-ones.

## Operation
- States: IDLE, HDR, ROWS.
- Capture condition: array_header[37]=1 and (state=IDLE, or current word has dout_eof=1 and is transferred this cycle). On capture:
  - header and all 38 rows are registered.
  - A 38-bit row-occupancy mask is formed (bit r = |row r).
  - hit_count is loaded.
  - State goes to HDR.
- array_header[37]=1 with capture condition false: frame discarded, overflow pulses, drop_count increments (saturating). The held frame is unaffected.
- HDR: dout=header, dout_row=63, dout_sof=1.
  - dout_eof=1 only if SKIP_EMPTY=1 and the occupancy mask is zero.
  - On transfer: next state ROWS with the pointer at the lowest eligible row, or IDLE if eof.
- ROWS: dout=row[ptr], dout_row=ptr.
  - Eligible rows: all rows when SKIP_EMPTY=0; rows with their mask bit set when SKIP_EMPTY=1.
  - Rows are sent in ascending order. dout_eof=1 on the highest eligible row.
  - On transfer: pointer advances to the next eligible row, or state returns to IDLE after eof.
- Words are never reordered, duplicated or skipped except empty rows under SKIP_EMPTY=1.
- dout, dout_row, dout_sof and dout_eof are stable while dout_valid=1 and dout_ready=0.

## Timing
- Reset values: dout=0, dout_row=0, dout_sof=0, dout_eof=0, dout_valid=0, busy=0, hit_count=0, overflow=0, drop_count=0. State = IDLE.
- Capture edge N, where array_header[37]=1 is sampled: header is presented with dout_valid=1 from cycle N+1. hit_count is updated at edge N.
- With dout_ready held at 1, one word transfers per cycle.
  - SKIP_EMPTY=0: a frame occupies 39 cycles, N+1..N+39.
  - SKIP_EMPTY=1: a frame occupies 1+k cycles, where k = number of nonzero rows.
- dout_valid deasserts the cycle after the eof transfer unless a frame was captured on that same edge. In that case the new header follows with no bubble.
- Frame arriving on an eof-transfer edge: it is accepted, not dropped.
- Reset asserted mid-frame: all outputs return to reset values immediately; the held frame is lost; drop_count is cleared.
- dout_ready is ignored when dout_valid=0.

## Test plan
- SKIP_EMPTY=0; frame with header=0x20_0000_AAAA|bit37, hit only row05 bit 12; ready=1 → 39 words on consecutive cycles.
  - dout_row sequence 63,0..37; sof on word 0, eof on row 37.
  - row 5 word = 0x1000; hit_count=1.
- SKIP_EMPTY=1; hits at (3,21),(4,21),(0,30) → 3 words: header, row 21=0x18, row 30=0x1 with eof; hit_count=3.
- SKIP_EMPTY=1; empty frame (only header bit37) → single word with sof=1 and eof=1; hit_count=0.
- Backpressure: ready toggles 1,0,0,1,…; a second frame arrives mid-stream.
  - Output is held stable during stalls; all words are delivered in order.
  - Second frame dropped: overflow pulses once, drop_count=1.
- Back-to-back: new frame asserted on the eof-transfer cycle → accepted; its header appears the next cycle, no bubble; drop_count unchanged.
- Reset asserted during ROWS (after row 10) → dout_valid=0, busy=0, counters 0 in the same cycle.
  - After release, a new frame streams normally from its header.

Source files
------------

// File: rtl/hitmap_serializer.sv
// hitmap_serializer
// Captures a one-cycle 38x38 hit-map frame (header plus 38 row words) and
// streams it out one 38-bit word per cycle over valid/ready. Each word is
// tagged with its row index (63 = header) and with start/end-of-frame
// markers. All-zero rows can be suppressed.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   array_header          frame header; bit 37 strobes a new frame
//   array_in00..37        hit rows y=0..37, valid with the strobe
//   dout/dout_row         output word and its row tag
//   dout_sof/dout_eof     first / last word of the frame
//   dout_valid/dout_ready output handshake
//   busy                  a frame is held
//   hit_count             popcount of the last captured frame
//   overflow, drop_count  dropped-frame pulse and saturating count
module hitmap_serializer #(
    parameter int SKIP_EMPTY = 1,
    parameter int DROP_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [37:0]       array_header,
    input  logic [37:0]       array_in00, array_in01, array_in02, array_in03,
    input  logic [37:0]       array_in04, array_in05, array_in06, array_in07,
    input  logic [37:0]       array_in08, array_in09, array_in10, array_in11,
    input  logic [37:0]       array_in12, array_in13, array_in14, array_in15,
    input  logic [37:0]       array_in16, array_in17, array_in18, array_in19,
    input  logic [37:0]       array_in20, array_in21, array_in22, array_in23,
    input  logic [37:0]       array_in24, array_in25, array_in26, array_in27,
    input  logic [37:0]       array_in28, array_in29, array_in30, array_in31,
    input  logic [37:0]       array_in32, array_in33, array_in34, array_in35,
    input  logic [37:0]       array_in36, array_in37,
    output logic [37:0]       dout,
    output logic [5:0]        dout_row,
    output logic              dout_sof,
    output logic              dout_eof,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              busy,
    output logic [10:0]       hit_count,
    output logic              overflow,
    output logic [DROP_W-1:0] drop_count
);

    localparam bit SKIP = (SKIP_EMPTY != 0);

    typedef enum logic [1:0] {IDLE, HDR, ROWS} state_t;

    state_t              state_q;
    logic [37:0]         rows_q [38];
    logic [37:0]         mask_q;
    logic [37:0]         dout_q;
    logic [5:0]          row_q;
    logic                sof_q, eof_q, valid_q, ovf_q;
    logic [10:0]         hits_q;
    logic [DROP_W-1:0]   drop_q;

    logic [37:0]         rows_in [38];
    logic [37:0]         mask_in;
    logic [10:0]         hits_in;
    logic [37:0]         elig;
    logic [5:0]          first_ptr, next_ptr;
    logic                first_last, next_last;
    logic                frame, xfer, cap;

    // Index of the lowest set bit (0 when none).
    function automatic logic [5:0] lowest_set(input logic [37:0] v);
        logic [5:0] idx;
        idx = 6'd0;
        for (int i = 37; i >= 0; i--)
            if (v[i]) idx = 6'(i);
        return idx;
    endfunction

    // Bits strictly above position p.
    function automatic logic [37:0] above(input logic [5:0] p);
        logic [37:0] m;
        for (int i = 0; i < 38; i++) m[i] = (i > int'(p));
        return m;
    endfunction

    assign rows_in[0]  = array_in00; assign rows_in[1]  = array_in01;
    assign rows_in[2]  = array_in02; assign rows_in[3]  = array_in03;
    assign rows_in[4]  = array_in04; assign rows_in[5]  = array_in05;
    assign rows_in[6]  = array_in06; assign rows_in[7]  = array_in07;
    assign rows_in[8]  = array_in08; assign rows_in[9]  = array_in09;
    assign rows_in[10] = array_in10; assign rows_in[11] = array_in11;
    assign rows_in[12] = array_in12; assign rows_in[13] = array_in13;
    assign rows_in[14] = array_in14; assign rows_in[15] = array_in15;
    assign rows_in[16] = array_in16; assign rows_in[17] = array_in17;
    assign rows_in[18] = array_in18; assign rows_in[19] = array_in19;
    assign rows_in[20] = array_in20; assign rows_in[21] = array_in21;
    assign rows_in[22] = array_in22; assign rows_in[23] = array_in23;
    assign rows_in[24] = array_in24; assign rows_in[25] = array_in25;
    assign rows_in[26] = array_in26; assign rows_in[27] = array_in27;
    assign rows_in[28] = array_in28; assign rows_in[29] = array_in29;
    assign rows_in[30] = array_in30; assign rows_in[31] = array_in31;
    assign rows_in[32] = array_in32; assign rows_in[33] = array_in33;
    assign rows_in[34] = array_in34; assign rows_in[35] = array_in35;
    assign rows_in[36] = array_in36; assign rows_in[37] = array_in37;

    always_comb begin
        hits_in = '0;
        mask_in = '0;
        for (int r = 0; r < 38; r++) begin
            mask_in[r] = |rows_in[r];
            hits_in    = hits_in + 11'($countones(rows_in[r]));
        end
    end

    // Without suppression every row is eligible, so first=0 and next=ptr+1.
    assign elig       = SKIP ? mask_q : '1;
    assign first_ptr  = lowest_set(elig);
    assign first_last = (elig & above(first_ptr)) == '0;
    assign next_ptr   = lowest_set(elig & above(row_q));
    assign next_last  = (elig & above(next_ptr)) == '0;

    assign frame = array_header[37];
    assign xfer  = valid_q && dout_ready;
    // A new frame is accepted while idle or on the edge its predecessor ends.
    assign cap   = frame && (state_q == IDLE || (xfer && eof_q));

    // Row storage is pure data; validity is tracked by the FSM.
    always_ff @(posedge clk)
        if (cap) rows_q <= rows_in;

    // Output word is registered and only changes on capture or transfer,
    // which keeps it stable under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mask_q  <= '0;
            dout_q  <= '0;
            row_q   <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            valid_q <= 1'b0;
            hits_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            ovf_q <= 1'b0;
            if (cap) begin
                state_q <= HDR;
                mask_q  <= mask_in;
                hits_q  <= hits_in;
                dout_q  <= array_header;
                row_q   <= 6'd63;
                sof_q   <= 1'b1;
                eof_q   <= SKIP && (mask_in == '0);
                valid_q <= 1'b1;
            end else begin
                if (frame) begin
                    ovf_q <= 1'b1;
                    if (drop_q != {DROP_W{1'b1}}) drop_q <= drop_q + DROP_W'(1);
                end
                if (xfer) begin
                    if (eof_q) begin
                        state_q <= IDLE;
                        dout_q  <= '0;
                        row_q   <= '0;
                        sof_q   <= 1'b0;
                        eof_q   <= 1'b0;
                        valid_q <= 1'b0;
                    end else if (state_q == HDR) begin
                        state_q <= ROWS;
                        dout_q  <= rows_q[first_ptr];
                        row_q   <= first_ptr;
                        sof_q   <= 1'b0;
                        eof_q   <= first_last;
                    end else begin
                        dout_q  <= rows_q[next_ptr];
                        row_q   <= next_ptr;
                        eof_q   <= next_last;
                    end
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_row   = row_q;
    assign dout_sof   = sof_q;
    assign dout_eof   = eof_q;
    assign dout_valid = valid_q;
    assign busy       = (state_q != IDLE);
    assign hit_count  = hits_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_hitmap_serializer.sv
module tb_hitmap_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic [37:0] hdr0, hdr1;
    logic [37:0] rows [38];
    logic        rdy0, rdy1;

    logic [37:0] d0, d1;
    logic [5:0]  r0, r1;
    logic        s0, s1, e0, e1, v0, v1, b0, b1, of0, of1;
    logic [10:0] hc0, hc1;
    logic [15:0] dc0, dc1;

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [37:0] d;
        logic [5:0]  r;
        logic        s;
        logic        e;
    } word_t;

    word_t q[$];

    always #5 clk = ~clk;

    // dut0: all rows sent; dut1: empty rows suppressed.
    hitmap_serializer #(.SKIP_EMPTY(0), .DROP_W(16)) u0 (
        .clk(clk), .rst(rst), .array_header(hdr0),
        .array_in00(rows[0]),  .array_in01(rows[1]),  .array_in02(rows[2]),  .array_in03(rows[3]),
        .array_in04(rows[4]),  .array_in05(rows[5]),  .array_in06(rows[6]),  .array_in07(rows[7]),
        .array_in08(rows[8]),  .array_in09(rows[9]),  .array_in10(rows[10]), .array_in11(rows[11]),
        .array_in12(rows[12]), .array_in13(rows[13]), .array_in14(rows[14]), .array_in15(rows[15]),
        .array_in16(rows[16]), .array_in17(rows[17]), .array_in18(rows[18]), .array_in19(rows[19]),
        .array_in20(rows[20]), .array_in21(rows[21]), .array_in22(rows[22]), .array_in23(rows[23]),
        .array_in24(rows[24]), .array_in25(rows[25]), .array_in26(rows[26]), .array_in27(rows[27]),
        .array_in28(rows[28]), .array_in29(rows[29]), .array_in30(rows[30]), .array_in31(rows[31]),
        .array_in32(rows[32]), .array_in33(rows[33]), .array_in34(rows[34]), .array_in35(rows[35]),
        .array_in36(rows[36]), .array_in37(rows[37]),
        .dout(d0), .dout_row(r0), .dout_sof(s0), .dout_eof(e0), .dout_valid(v0),
        .dout_ready(rdy0), .busy(b0), .hit_count(hc0), .overflow(of0), .drop_count(dc0)
    );

    hitmap_serializer #(.SKIP_EMPTY(1), .DROP_W(16)) u1 (
        .clk(clk), .rst(rst), .array_header(hdr1),
        .array_in00(rows[0]),  .array_in01(rows[1]),  .array_in02(rows[2]),  .array_in03(rows[3]),
        .array_in04(rows[4]),  .array_in05(rows[5]),  .array_in06(rows[6]),  .array_in07(rows[7]),
        .array_in08(rows[8]),  .array_in09(rows[9]),  .array_in10(rows[10]), .array_in11(rows[11]),
        .array_in12(rows[12]), .array_in13(rows[13]), .array_in14(rows[14]), .array_in15(rows[15]),
        .array_in16(rows[16]), .array_in17(rows[17]), .array_in18(rows[18]), .array_in19(rows[19]),
        .array_in20(rows[20]), .array_in21(rows[21]), .array_in22(rows[22]), .array_in23(rows[23]),
        .array_in24(rows[24]), .array_in25(rows[25]), .array_in26(rows[26]), .array_in27(rows[27]),
        .array_in28(rows[28]), .array_in29(rows[29]), .array_in30(rows[30]), .array_in31(rows[31]),
        .array_in32(rows[32]), .array_in33(rows[33]), .array_in34(rows[34]), .array_in35(rows[35]),
        .array_in36(rows[36]), .array_in37(rows[37]),
        .dout(d1), .dout_row(r1), .dout_sof(s1), .dout_eof(e1), .dout_valid(v1),
        .dout_ready(rdy1), .busy(b1), .hit_count(hc1), .overflow(of1), .drop_count(dc1)
    );

    // Reference model: expected word sequence for the rows currently driven.
    function automatic void push_frame(input bit skip, input logic [37:0] h);
        int    last;
        word_t x;
        last = -1;
        for (int r = 0; r < 38; r++)
            if (!skip || rows[r] != '0) last = r;
        x.d = h; x.r = 6'd63; x.s = 1'b1; x.e = (last < 0);
        q.push_back(x);
        for (int r = 0; r < 38; r++) begin
            if (!skip || rows[r] != '0) begin
                x.d = rows[r]; x.r = 6'(r); x.s = 1'b0; x.e = (r == last);
                q.push_back(x);
            end
        end
    endfunction

    function automatic logic [10:0] exp_hits();
        int n;
        n = 0;
        for (int r = 0; r < 38; r++) n += $countones(rows[r]);
        return 11'(n);
    endfunction

    function automatic void clear_rows();
        for (int r = 0; r < 38; r++) rows[r] = '0;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({d0, r0, s0, e0, v0, b0, hc0, of0, dc0} !== '0) begin
            $display("FAIL reset_u0: got %h required 0", {d0, r0, s0, e0, v0, b0, hc0, of0, dc0});
        end else passed++;
        total++;
        if ({d1, r1, s1, e1, v1, b1, hc1, of1, dc1} !== '0) begin
            $display("FAIL reset_u1: got %h required 0", {d1, r1, s1, e1, v1, b1, hc1, of1, dc1});
        end else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({v0, b0, v1, b1} !== 4'b0) begin
            $display("FAIL reset_idle: valid/busy %b required 0000", {v0, b0, v1, b1});
        end else passed++;
    endtask

    task automatic test_full_frame();
        word_t w;
        clear_rows();
        rows[5] = 38'h1000;
        hdr0 = 38'h20_0000_AAAA;
        rdy0 = 1'b1;
        push_frame(1'b0, hdr0);
        @(negedge clk);
        hdr0 = '0;
        total++;
        if (hc0 !== 11'd1) $display("FAIL full_hits: got %0d required 1", hc0);
        else passed++;
        // 39 words on consecutive cycles, no gaps.
        for (int c = 0; c < 39; c++) begin
            w = (q.size() > 0) ? q.pop_front() : '0;
            total++;
            if (v0 !== 1'b1 || {d0, r0, s0, e0} !== w)
                $display("FAIL full_word%0d: valid=%b got %h required %h", c, v0, {d0, r0, s0, e0}, w);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (v0 !== 1'b0 || b0 !== 1'b0) $display("FAIL full_end: valid=%b busy=%b required 0 0", v0, b0);
        else passed++;
    endtask

    task automatic test_skip_sparse();
        word_t w;
        clear_rows();
        rows[21] = 38'h18;
        rows[30] = 38'h1;
        hdr1 = 38'h20_0000_0000 | 38'h123;
        rdy1 = 1'b1;
        push_frame(1'b1, hdr1);
        @(negedge clk);
        hdr1 = '0;
        total++;
        if (hc1 !== 11'd3) $display("FAIL sparse_hits: got %0d required 3", hc1);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            w = (q.size() > 0) ? q.pop_front() : '0;
            total++;
            if (v1 !== 1'b1 || {d1, r1, s1, e1} !== w)
                $display("FAIL sparse_word%0d: valid=%b got %h required %h", c, v1, {d1, r1, s1, e1}, w);
            else passed++;
            @(negedge clk);
        end
        total++;
        if (v1 !== 1'b0) $display("FAIL sparse_end: valid=%b required 0", v1);
        else passed++;
    endtask

    task automatic test_skip_empty();
        clear_rows();
        hdr1 = 38'h20_0000_0000;
        rdy1 = 1'b1;
        @(negedge clk);
        hdr1 = '0;
        total++;
        if ({v1, d1, r1, s1, e1, hc1} !== {1'b1, 38'h20_0000_0000, 6'd63, 1'b1, 1'b1, 11'd0})
            $display("FAIL empty_word: got v=%b d=%h row=%0d sof=%b eof=%b hits=%0d required 1 2000000000 63 1 1 0",
                     v1, d1, r1, s1, e1, hc1);
        else passed++;
        @(negedge clk);
        total++;
        if (v1 !== 1'b0 || b1 !== 1'b0) $display("FAIL empty_end: valid=%b busy=%b required 0 0", v1, b1);
        else passed++;
    endtask

    task automatic test_backpressure();
        word_t w, hold;
        bit    held;
        int    ovf_seen;
        clear_rows();
        for (int r = 0; r < 38; r++) rows[r] = {6'($urandom), $urandom};
        hdr0 = {1'b1, 37'($urandom)};
        push_frame(1'b0, hdr0);
        held = 1'b0;
        ovf_seen = 0;
        @(negedge clk);
        hdr0 = '0;
        for (int c = 0; c < 400 && q.size() > 0; c++) begin
            rdy0 = (c % 3 == 0);
            if (held) begin
                total++;
                if (v0 !== 1'b1 || {d0, r0, s0, e0} !== hold)
                    $display("FAIL bp_stable%0d: got %h required %h", c, {d0, r0, s0, e0}, hold);
                else passed++;
            end
            held = 1'b0;
            ovf_seen += int'(of0);
            if (v0 && rdy0) begin
                w = q.pop_front();
                total++;
                if ({d0, r0, s0, e0} !== w)
                    $display("FAIL bp_word%0d: got %h required %h", c, {d0, r0, s0, e0}, w);
                else passed++;
            end else if (v0) begin
                hold = {d0, r0, s0, e0};
                held = 1'b1;
            end
            hdr0 = '0;
            // Second frame mid-stream must be dropped.
            if (c == 10) begin
                for (int r = 0; r < 38; r++) rows[r] = ~rows[r];
                hdr0 = {1'b1, 37'h15};
            end
            @(negedge clk);
        end
        ovf_seen += int'(of0);
        total++;
        if (q.size() != 0) $display("FAIL bp_timeout: %0d words left required 0", q.size());
        else passed++;
        total++;
        if (ovf_seen != 1) $display("FAIL bp_overflow: pulses %0d required 1", ovf_seen);
        else passed++;
        total++;
        if (dc0 !== 16'd1) $display("FAIL bp_drops: got %0d required 1", dc0);
        else passed++;
        q.delete();
        rdy0 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        word_t w;
        bit    sent, check_next;
        logic [37:0] hb;
        int    ovf_seen;
        clear_rows();
        rows[2] = 38'h5;
        rows[9] = 38'h1;
        hdr1 = 38'h20_0000_0000 | 38'h77;
        rdy1 = 1'b1;
        push_frame(1'b1, hdr1);
        sent = 1'b0;
        check_next = 1'b0;
        ovf_seen = 0;
        @(negedge clk);
        hdr1 = '0;
        for (int c = 0; c < 40 && q.size() > 0; c++) begin
            ovf_seen += int'(of1);
            if (check_next) begin
                total++;
                if (v1 !== 1'b1 || s1 !== 1'b1)
                    $display("FAIL b2b_nobubble: valid=%b sof=%b required 1 1", v1, s1);
                else passed++;
                check_next = 1'b0;
            end
            hdr1 = '0;
            if (v1) begin
                w = q.pop_front();
                total++;
                if ({d1, r1, s1, e1} !== w)
                    $display("FAIL b2b_word%0d: got %h required %h", c, {d1, r1, s1, e1}, w);
                else passed++;
                if (e1 && !sent) begin
                    clear_rows();
                    rows[0] = 38'h7;
                    hb = 38'h20_0000_0000 | 38'hBEEF;
                    hdr1 = hb;
                    push_frame(1'b1, hb);
                    sent = 1'b1;
                    check_next = 1'b1;
                end
            end
            @(negedge clk);
        end
        hdr1 = '0;
        total++;
        if (q.size() != 0 || !sent) $display("FAIL b2b_timeout: %0d words left sent=%b required 0 1", q.size(), sent);
        else passed++;
        total++;
        if (dc1 !== 16'd0 || ovf_seen != 0) $display("FAIL b2b_drops: drops %0d pulses %0d required 0 0", dc1, ovf_seen);
        else passed++;
        total++;
        if (hc1 !== 11'd3) $display("FAIL b2b_hits: got %0d required 3", hc1);
        else passed++;
        q.delete();
    endtask

    task automatic test_reset_mid_frame();
        word_t w;
        bit    reached;
        clear_rows();
        for (int r = 0; r < 38; r++) rows[r] = {6'($urandom), $urandom};
        hdr0 = {1'b1, 37'h0ABC};
        rdy0 = 1'b1;
        push_frame(1'b0, hdr0);
        reached = 1'b0;
        @(negedge clk);
        hdr0 = '0;
        for (int c = 0; c < 60; c++) begin
            if (v0) begin
                w = q.pop_front();
                total++;
                if ({d0, r0, s0, e0} !== w)
                    $display("FAIL mid_word%0d: got %h required %h", c, {d0, r0, s0, e0}, w);
                else passed++;
                if (r0 == 6'd10 && !s0) begin
                    reached = 1'b1;
                    break;
                end
            end
            @(negedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (!reached || {v0, b0, hc0, dc0, of0, d0, s0, e0} !== '0)
            $display("FAIL mid_reset: reached=%b valid=%b busy=%b hits=%0d drops=%0d required 1 0 0 0 0",
                     reached, v0, b0, hc0, dc0);
        else passed++;
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        clear_rows();
        rows[0]  = 38'h3;
        rows[37] = 38'h20_0000_0000;
        hdr0 = {1'b1, 37'h5A5A};
        push_frame(1'b0, hdr0);
        @(negedge clk);
        hdr0 = '0;
        total++;
        if (hc0 !== exp_hits()) $display("FAIL mid_hits: got %0d required %0d", hc0, exp_hits());
        else passed++;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            if (v0) begin
                w = q.pop_front();
                total++;
                if ({d0, r0, s0, e0} !== w)
                    $display("FAIL post_word%0d: got %h required %h", c, {d0, r0, s0, e0}, w);
                else passed++;
            end
            @(negedge clk);
        end
        total++;
        if (q.size() != 0) $display("FAIL post_timeout: %0d words left required 0", q.size());
        else passed++;
    endtask

    initial begin
        rst  = 1'b1;
        hdr0 = '0;
        hdr1 = '0;
        rdy0 = 1'b0;
        rdy1 = 1'b0;
        clear_rows();
        repeat (2) @(negedge clk);
        test_reset();
        test_full_frame();
        test_skip_sparse();
        test_skip_empty();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
